// File: rtl/dmem_pkg.sv
// Shared defaults and FSM state encoding for the byte-copy DMA engine.
package dmem_pkg;

    localparam int unsigned DMEM_ADDR_W = 8;
    localparam int unsigned DMEM_DATA_W = 8;
    localparam int unsigned DMEM_DEPTH  = 32;
    localparam int unsigned DMA_LEN_W   = 6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } dma_state_t;

endpackage

// File: rtl/dma_copy_engine.sv
// Single-port memory-to-memory byte copier: one read cycle then one write cycle per byte,
// ascending addresses, with range checking on request.
module dma_copy_engine
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W    = DMEM_ADDR_W,
    parameter int unsigned DATA_W    = DMEM_DATA_W,
    parameter int unsigned MEM_DEPTH = DMEM_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    src_addr,
    input  logic [ADDR_W-1:0]    dst_addr,
    input  logic [DMA_LEN_W-1:0] length,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [ADDR_W-1:0]    Address,
    output logic [DATA_W-1:0]    WriteData,
    output logic                 MemRead,
    output logic                 MemWrite,
    input  logic [DATA_W-1:0]    ReadData
);

    localparam int unsigned LEN_W = DMA_LEN_W;
    localparam int unsigned SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;

    dma_state_t         r_state;
    dma_state_t         w_next;
    logic [ADDR_W-1:0]  r_src;
    logic [ADDR_W-1:0]  r_dst;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_i;
    logic [DATA_W-1:0]  r_hold;

    logic [SUM_W-1:0]   w_src_end;
    logic [SUM_W-1:0]   w_dst_end;
    logic               w_range_err;
    logic               w_accept;
    logic               w_last;

    // End addresses are one bit wider than either operand so they cannot wrap.
    assign w_src_end   = SUM_W'(src_addr) + SUM_W'(length);
    assign w_dst_end   = SUM_W'(dst_addr) + SUM_W'(length);
    assign w_range_err = (w_src_end > SUM_W'(MEM_DEPTH)) || (w_dst_end > SUM_W'(MEM_DEPTH));
    assign w_accept    = start && (length != '0) && !w_range_err;
    assign w_last      = (r_i == (r_len - LEN_W'(1)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        w_next = ST_DONE;
                    end else if (w_range_err) begin
                        w_next = ST_ERR;
                    end else begin
                        w_next = ST_RD;
                    end
                end
            end
            ST_RD:   w_next = ST_WR;
            ST_WR:   w_next = w_last ? ST_DONE : ST_RD;
            ST_DONE: w_next = ST_IDLE;
            ST_ERR:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Request latch, byte index and read-data holding register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_src  <= '0;
            r_dst  <= '0;
            r_len  <= '0;
            r_i    <= '0;
            r_hold <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_src <= src_addr;
                        r_dst <= dst_addr;
                        r_len <= length;
                        r_i   <= '0;
                    end
                end
                ST_RD:   r_hold <= ReadData;
                ST_WR:   r_i    <= r_i + LEN_W'(1);
                default: ;
            endcase
        end
    end

    // Memory-side signals decode from registers only, never from the request ports.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        Address   = '0;
        WriteData = '0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        unique case (r_state)
            ST_IDLE: ;
            ST_RD: begin
                busy    = 1'b1;
                Address = r_src + ADDR_W'(r_i);
                MemRead = 1'b1;
            end
            ST_WR: begin
                busy      = 1'b1;
                Address   = r_dst + ADDR_W'(r_i);
                WriteData = r_hold;
                MemWrite  = 1'b1;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            ST_ERR: begin
                busy  = 1'b1;
                error = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Bench for dma_copy_engine: paired 32-byte data memory, directed table, corner sequences
// and random requests checked against an array-level copy model.
module tb_dma_copy_engine;

    localparam int unsigned MEM_BYTES = 32;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] src_addr;
    logic [7:0] dst_addr;
    logic [5:0] length;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] Address;
    logic [7:0] WriteData;
    logic       MemRead;
    logic       MemWrite;
    logic [7:0] ReadData;

    logic [7:0] mem     [MEM_BYTES];
    logic [7:0] ref_mem [MEM_BYTES];
    logic       load;

    int n_checks;
    int n_fail;

    dma_copy_engine #(.ADDR_W(8), .DATA_W(8), .MEM_DEPTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .Address   (Address),
        .WriteData (WriteData),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .ReadData  (ReadData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int k);
        if (k < 16) return 8'(k);
        if (k == 16) return 8'h00;
        return 8'(9'h110 - k);
    endfunction

    // Data memory: combinational read, write on rising edge.
    assign ReadData = (int'(Address) < MEM_BYTES) ? mem[Address[4:0]] : 8'h00;

    always @(posedge clk) begin
        if (load) begin
            for (int k = 0; k < MEM_BYTES; k++) mem[k] <= init_val(k);
        end else if (MemWrite && (int'(Address) < MEM_BYTES)) begin
            mem[Address[4:0]] <= WriteData;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic chk_mem(input string name);
        int bad;
        bad = -1;
        n_checks++;
        for (int k = 0; k < MEM_BYTES; k++) begin
            if (bad < 0 && mem[k] !== ref_mem[k]) bad = k;
        end
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s mem[%0d] got=%h exp=%h", name, bad, mem[bad], ref_mem[bad]);
        end
    endtask

    task automatic reload();
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        for (int k = 0; k < MEM_BYTES; k++) ref_mem[k] = init_val(k);
    endtask

    // Reference: rejected or empty requests leave memory alone; accepted ones copy forward.
    function automatic void ref_apply(input int s, input int d, input int l,
                                      output int kind, output int exp_busy, output int xfer);
        if (l == 0) begin
            kind = 0; exp_busy = 1; xfer = 0;
        end else if (s + l > MEM_BYTES || d + l > MEM_BYTES) begin
            kind = 1; exp_busy = 1; xfer = 0;
        end else begin
            for (int k = 0; k < l; k++) ref_mem[d + k] = ref_mem[s + k];
            kind = 0; exp_busy = 2 * l + 1; xfer = l;
        end
    endfunction

    task automatic run_txn(input int s, input int d, input int l, input bit intrude,
                           output int busy_cyc, output int ev_cyc, output int n_done,
                           output int n_err, output int n_rd, output int n_wr,
                           output int addr_bad, output int excl_bad, output int timeout);
        busy_cyc = 0; ev_cyc = 0; n_done = 0; n_err = 0; n_rd = 0; n_wr = 0;
        addr_bad = 0; excl_bad = 0; timeout = 1;
        @(negedge clk);
        start = 1'b1; src_addr = 8'(s); dst_addr = 8'(d); length = 6'(l);
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (c > 1) @(negedge clk);
            if (intrude && c == 3) begin
                start = 1'b1; src_addr = 8'd5; dst_addr = 8'd25; length = 6'd2;
            end
            if (intrude && c == 4) start = 1'b0;
            if (!busy) begin
                timeout = 0;
                break;
            end
            busy_cyc++;
            if (done)  begin n_done++; ev_cyc = c; end
            if (error) begin n_err++;  ev_cyc = c; end
            if (MemRead && MemWrite) excl_bad++;
            if (MemRead) begin
                if (int'(Address) != s + n_rd) addr_bad++;
                n_rd++;
            end
            if (MemWrite) begin
                if (int'(Address) != d + n_wr) addr_bad++;
                n_wr++;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_txn(input string tag, input int s, input int d, input int l,
                             input int exp_kind, input int exp_busy, input int exp_xfer,
                             input bit intrude);
        int busy_cyc, ev_cyc, n_done, n_err, n_rd, n_wr, addr_bad, excl_bad, timeout;
        run_txn(s, d, l, intrude, busy_cyc, ev_cyc, n_done, n_err, n_rd, n_wr,
                addr_bad, excl_bad, timeout);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_busy"}, busy_cyc, exp_busy);
        chk({tag, "_done"}, n_done, (exp_kind == 0) ? 1 : 0);
        chk({tag, "_error"}, n_err, (exp_kind == 1) ? 1 : 0);
        chk({tag, "_evcyc"}, ev_cyc, exp_busy);
        chk({tag, "_reads"}, n_rd, exp_xfer);
        chk({tag, "_writes"}, n_wr, exp_xfer);
        chk({tag, "_addr"}, addr_bad, 0);
        chk({tag, "_excl"}, excl_bad, 0);
        chk_mem({tag, "_mem"});
    endtask

    typedef struct {
        int src;
        int dst;
        int len;
        int exp_kind;
        int exp_busy;
        int exp_xfer;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int kind, eb, xf;
        int seen_busy, n_writes, seen_done, s, d, l, lim;
        string tag;

        vecs[0] = '{0, 20, 4, 0, 9, 4};
        vecs[1] = '{3, 7, 0, 0, 1, 0};
        vecs[2] = '{30, 0, 4, 1, 1, 0};
        vecs[3] = '{0, 1, 3, 0, 7, 3};
        vecs[4] = '{28, 0, 4, 0, 9, 4};
        vecs[5] = '{0, 29, 4, 1, 1, 0};
        vecs[6] = '{0, 0, 32, 0, 65, 32};
        vecs[7] = '{1, 0, 32, 1, 1, 0};
        vecs[8] = '{31, 5, 1, 0, 3, 1};

        n_checks = 0;
        n_fail   = 0;
        load     = 1'b0;
        start    = 1'b0;
        src_addr = 8'h00;
        dst_addr = 8'h00;
        length   = 6'd0;
        reset    = 1'b1;
        #1;
        chk("reset_outputs", int'({busy, done, error, MemRead, MemWrite, Address, WriteData}), 0);
        reload();
        @(negedge clk);
        reset = 1'b0;

        // Directed table.
        for (int i = 0; i < 9; i++) begin
            reload();
            ref_apply(vecs[i].src, vecs[i].dst, vecs[i].len, kind, eb, xf);
            tag = $sformatf("vec%0d", i);
            check_txn(tag, vecs[i].src, vecs[i].dst, vecs[i].len,
                      vecs[i].exp_kind, vecs[i].exp_busy, vecs[i].exp_xfer, 1'b0);
        end

        // Absolute byte values for the basic copy and the overlapping forward copy.
        reload();
        ref_apply(0, 20, 4, kind, eb, xf);
        check_txn("basic", 0, 20, 4, 0, 9, 4, 1'b0);
        for (int k = 0; k < 4; k++) chk($sformatf("basic_byte%0d", k), int'(mem[20 + k]), k);
        reload();
        ref_apply(0, 1, 3, kind, eb, xf);
        check_txn("overlap", 0, 1, 3, 0, 7, 3, 1'b0);
        for (int k = 1; k < 4; k++) chk($sformatf("overlap_byte%0d", k), int'(mem[k]), 0);

        // A second start while busy must be ignored.
        reload();
        ref_apply(0, 20, 4, kind, eb, xf);
        check_txn("intrude", 0, 20, 4, 0, 9, 4, 1'b1);
        seen_busy = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (busy) seen_busy++;
        end
        chk("intrude_idle_after", seen_busy, 0);

        // Reset during the 4th write cycle aborts that byte with no done pulse.
        reload();
        @(negedge clk);
        start = 1'b1; src_addr = 8'd0; dst_addr = 8'd16; length = 6'd8;
        @(negedge clk);
        start = 1'b0;
        n_writes  = 0;
        seen_done = 0;
        for (int c = 1; c <= 100; c++) begin
            if (c > 1) @(negedge clk);
            if (done) seen_done++;
            if (MemWrite) n_writes++;
            if (n_writes == 4) break;
        end
        chk("abort_reached_wr4", n_writes, 4);
        reset = 1'b1;
        #1;
        chk("abort_outputs", int'({busy, done, error, MemRead, MemWrite, Address, WriteData}), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        if (done) seen_done++;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        chk("abort_no_done", seen_done, 0);
        chk("abort_m16", int'(mem[16]), 8'h00);
        chk("abort_m17", int'(mem[17]), 8'h01);
        chk("abort_m18", int'(mem[18]), 8'h02);
        chk("abort_m19", int'(mem[19]), 8'hFD);

        // Random requests against the array model, memory carried across transactions.
        reload();
        for (int t = 0; t < 40; t++) begin
            s = int'($urandom_range(0, 31));
            d = int'($urandom_range(0, 31));
            l = int'($urandom_range(0, 32));
            if ($urandom_range(0, 3) != 0) begin
                lim = MEM_BYTES - ((s > d) ? s : d);
                l = int'($urandom_range(0, lim));
            end
            ref_apply(s, d, l, kind, eb, xf);
            tag = $sformatf("rnd%0d", t);
            check_txn(tag, s, d, l, kind, eb, xf, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_copy_engine.md
DMA_COPY_ENGINE -- requirements
Module: dma_copy_engine

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 SHALL have parameter MEM_DEPTH, default 32, number of addressable bytes.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  copy request; sampled only in IDLE.
REQ-007 SHALL have port src_addr  input  ADDR_W  first source byte address.
REQ-008 SHALL have port dst_addr  input  ADDR_W  first destination byte address.
REQ-009 SHALL have port length  input  6  byte count, 0..MEM_DEPTH.
REQ-010 SHALL have port busy  output  1  high in every non-IDLE state.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port error  output  1  one-cycle pulse for a rejected request.
REQ-013 SHALL have port Address  output  ADDR_W  memory address.
REQ-014 SHALL have port WriteData  output  DATA_W  memory write data.
REQ-015 SHALL have port MemRead  output  1  memory read strobe.
REQ-016 SHALL have port MemWrite  output  1  memory write strobe.
REQ-017 SHALL have port ReadData  input  DATA_W  combinational read data from memory.

Function
REQ-018 SHALL implement FSM states IDLE, RD, WR, DONE, ERR.
REQ-019 In IDLE with start=1: length=0 -> DONE; src_addr+length>MEM_DEPTH or dst_addr+length>MEM_DEPTH (computed 9-bit, no wrap) -> ERR; otherwise latch src, dst, length, clear index i, go to RD.
REQ-020 RD SHALL drive Address=src+i, MemRead=1, MemWrite=0, and capture ReadData into a holding register at the clock edge leaving RD; next state WR.
REQ-021 WR SHALL drive Address=dst+i, WriteData=holding register, MemWrite=1, MemRead=0 for exactly one cycle; then i increments, and the next state is DONE if i==length-1, else RD.
REQ-022 DONE SHALL assert done for one cycle, then return to IDLE; ERR SHALL assert error for one cycle, then return to IDLE.
REQ-023 Copy SHALL proceed in ascending address order, byte by byte; overlapping ranges get no special handling (forward-copy semantics).
REQ-024 Latency: for L>0 accepted at edge E0, done SHALL be high in the cycle following edge E(2L); busy SHALL be high for 2L+1 cycles.
REQ-025 start, src_addr, dst_addr, and length SHALL be ignored outside IDLE.
REQ-026 Address, WriteData, MemRead, and MemWrite SHALL derive only from registered state, with no combinational path from input ports; all are 0 in IDLE, DONE, and ERR.
REQ-027 MemRead and MemWrite SHALL never be high in the same cycle.

Reset
REQ-028 While reset=1, the FSM SHALL be IDLE, i/holding/latched registers SHALL be 0, and all outputs SHALL be 0, taking effect immediately without waiting for clk.
REQ-029 Reset mid-copy SHALL abort without completing the current byte; bytes already written remain written; no done pulse is issued.

Structure
REQ-030 Package dmem_pkg SHALL hold ADDR_W, DATA_W, MEM_DEPTH defaults and the FSM state typedef.
REQ-031 SHALL be one flat module; no sub-module.
REQ-032 Bench SHALL pair the block with the team's DataMemory block, with initial contents mem[i]=i for i 0..15, mem[16]=0x00, and mem[17..31]=0xFF..0xF1.

Verification
REQ-033 src=0, dst=20, length=4 -> mem[20..23]=00,01,02,03; busy 9 cycles; done one cycle after edge E8.
REQ-034 length=0 -> done pulse next cycle; MemRead and MemWrite never asserted.
REQ-035 src=30, length=4 -> error pulse; no strobes; memory unchanged.
REQ-036 src=0, dst=16, length=8, reset asserted during the 4th WR cycle -> strobes low at once; mem[16..18]=00,01,02; mem[19]=0xFD.
REQ-037 start with src=5, dst=25, length=2 pulsed while busy -> ignored; the original copy completes unaffected.
REQ-038 src=0, dst=1, length=3 -> forward copy gives mem[1..3]=00,00,00.
